// File: rtl/ltc2308_emulator_pkg.sv
// ---------------------------------------------------------------------------
// ltc2308_pkg
// Shared definitions for the LTC2308 serial-interface emulator:
//   - state_t       : responder FSM states
//   - CFG_*         : bit positions inside the 6-bit config word
//                     {S/D, O/S, S1, S0, UNI, SLP}
//   - RESET_CFG     : single-ended ch0, unipolar, awake
//   - DATA_BITS     : conversion result width
//   - CMD_BITS      : config word width
//   - calc_result() : result word for a given channel snapshot and config
// ---------------------------------------------------------------------------
package ltc2308_pkg;

  localparam int DATA_BITS = 12;
  localparam int CMD_BITS  = 6;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [CMD_BITS-1:0]  RESET_CFG = 6'b100010;
  localparam logic [DATA_BITS-1:0] SIGN_FLIP = 12'h800;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_READY = 3'd2,
    ST_SHIFT = 3'd3,
    ST_SLEEP = 3'd4
  } state_t;

  // {S1, S0, O/S} addresses the channel directly, which is what makes the
  // odd-looking 8/C/9/D/A/E/B/F nibble order land on ch0..7. In differential
  // mode the same address is the + input and its O/S-flipped twin is the -.
  function automatic logic [DATA_BITS-1:0] calc_result(
    input logic [8*DATA_BITS-1:0] data,
    input logic [CMD_BITS-1:0]    cfg
  );
    logic [2:0]           ch_pos;
    logic [2:0]           ch_neg;
    logic [DATA_BITS-1:0] v_pos;
    logic [DATA_BITS-1:0] v_neg;
    logic [DATA_BITS:0]   diff;
    logic [DATA_BITS-1:0] res;
    ch_pos = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    ch_neg = {cfg[CFG_S1], cfg[CFG_S0], ~cfg[CFG_OS]};
    v_pos  = data[int'(ch_pos)*DATA_BITS +: DATA_BITS];
    v_neg  = data[int'(ch_neg)*DATA_BITS +: DATA_BITS];
    diff   = {1'b0, v_pos} - {1'b0, v_neg};
    if (cfg[CFG_SD]) begin
      res = cfg[CFG_UNI] ? v_pos : (v_pos ^ SIGN_FLIP);
    end else if (cfg[CFG_UNI]) begin
      // |diff| never exceeds 4095, so only the negative side needs clamping.
      res = diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
    end else begin
      res = diff[DATA_BITS:1];
    end
    return res;
  endfunction

endpackage

// File: rtl/ltc2308_emulator_if.sv
// ---------------------------------------------------------------------------
// ltc2308_emulator_if
// The four-wire LTC2308 serial bus.
//   ADC_CONVST : conversion start   (controller -> ADC)
//   ADC_SCK    : serial clock       (controller -> ADC)
//   ADC_SDI    : config bits, MSB first (controller -> ADC)
//   ADC_SDO    : result bits, MSB first (ADC -> controller)
// master = ADC controller side, slave = ADC (emulator) side.
// ---------------------------------------------------------------------------
interface ltc2308_emulator_if;
  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (
    output ADC_CONVST,
    output ADC_SCK,
    output ADC_SDI,
    input  ADC_SDO
  );

  modport slave (
    input  ADC_CONVST,
    input  ADC_SCK,
    input  ADC_SDI,
    output ADC_SDO
  );
endinterface

// File: rtl/ltc2308_emu_sync.sv
// ---------------------------------------------------------------------------
// ltc2308_emu_sync
// Multi-flop synchronizer followed by one edge-detect flop.
//   clk      : emulator clock
//   reset_n  : async active-low reset, clears every flop
//   i_async  : input asynchronous to clk
//   o_level  : synchronized level
//   o_rise   : one-cycle pulse on a synchronized 0->1
//   o_fall   : one-cycle pulse on a synchronized 1->0
// STAGES must be at least 2. The edge pulses are combinational from flops,
// so the consumer acts on the edge STAGES+1 clocks after the input moves.
// ---------------------------------------------------------------------------
module ltc2308_emu_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/ltc2308_emulator.sv
// ---------------------------------------------------------------------------
// ltc2308_emulator
// Synthesizable responder for the LTC2308 serial interface: answers the ADC
// controller's CONVST/SCK/SDI with results built from a parallel ch_data bus.
//   clk           : emulator clock, at least 4x ADC_SCK
//   reset_n       : async active-low reset
//   ch_data       : eight 12-bit channel values, ch N = ch_data[12N+11:12N]
//   adc           : serial bus (slave side)
//   busy          : high while the emulated conversion runs
//   active_cfg    : config word of the current / last conversion
//   sample_strobe : one-cycle pulse when a result is latched
// Optional build macro LTC2308_EMU_NOISE_EN: adds a 16-bit Galois LFSR that
// steps once per conversion and dithers result[1:0].
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset or wake-up, waiting for CONVST
// ST_CONV  | conversion running, busy high, CONVST ignored
// ST_READY | result ready, SDO holds the MSB, no SCK falling edge yet
// ST_SHIFT | result being shifted out, SDI being captured
// ST_SLEEP | powered down, next CONVST only wakes up
// ---------------------------------------------------------------------------
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*DATA_BITS-1:0] ch_data,
  ltc2308_emulator_if.slave      adc,
  output logic                   busy,
  output logic [CMD_BITS-1:0]    active_cfg,
  output logic                   sample_strobe
);

  localparam int                CNT_W     = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [2:0]        CAP_FULL  = 3'(CMD_BITS);

  logic w_convst_lvl, w_convst_rise, w_convst_fall;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_sdi_lvl, w_sdi_rise, w_sdi_fall;

  ltc2308_emu_sync #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc.ADC_CONVST),
    .o_level (w_convst_lvl),
    .o_rise  (w_convst_rise),
    .o_fall  (w_convst_fall)
  );

  ltc2308_emu_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc.ADC_SCK),
    .o_level (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // SDI goes through the same depth as SCK, so its level at a detected SCK
  // rise is the level the controller presented at the real SCK rise.
  ltc2308_emu_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc.ADC_SDI),
    .o_level (w_sdi_lvl),
    .o_rise  (w_sdi_rise),
    .o_fall  (w_sdi_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_convst_lvl, w_convst_fall, w_sck_lvl, w_sdi_rise, w_sdi_fall};

  state_t                r_state;
  logic                  r_sdo;
  logic                  r_busy;
  logic                  r_strobe;
  logic [CMD_BITS-1:0]   r_active;
  logic [CMD_BITS-1:0]   r_pending;
  logic [CMD_BITS-1:0]   r_cap;
  logic [2:0]            r_cap_cnt;
  logic [DATA_BITS-1:0]  r_result;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_idx;
  logic                  r_tail;

  logic [CMD_BITS-1:0]   w_next_cfg;
  logic [DATA_BITS-1:0]  w_exact;
  logic [DATA_BITS-1:0]  w_result;

  // A full 6-bit word shifted in since the last conversion end replaces the
  // pending config; a partial word is discarded.
  assign w_next_cfg = (r_cap_cnt == CAP_FULL) ? r_cap : r_pending;
  assign w_exact    = calc_result(ch_data, w_next_cfg);

`ifdef LTC2308_EMU_NOISE_EN
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] r_lfsr;
  logic        w_conv_start;

  assign w_conv_start = w_convst_rise && !w_next_cfg[CFG_SLP] &&
                        ((r_state == ST_IDLE) || (r_state == ST_READY) ||
                         (r_state == ST_SHIFT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_conv_start) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign w_result = w_exact ^ {{(DATA_BITS-2){1'b0}}, r_lfsr[1:0]};
`else
  assign w_result = w_exact;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sdo     <= 1'b0;
      r_busy    <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= RESET_CFG;
      r_pending <= RESET_CFG;
      r_cap     <= '0;
      r_cap_cnt <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tail    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE, ST_READY, ST_SHIFT: begin
          if (w_convst_rise) begin
            r_pending <= w_next_cfg;
            r_active  <= w_next_cfg;
            r_sdo     <= 1'b0;
            if (w_next_cfg[CFG_SLP]) begin
              // The sleep word is consumed here; without clearing the count
              // the same word would be re-applied after wake-up.
              r_cap_cnt <= '0;
              r_state   <= ST_SLEEP;
            end else begin
              r_result <= w_result;
              r_strobe <= 1'b1;
              r_busy   <= 1'b1;
              r_cnt    <= CONV_LOAD;
              r_state  <= ST_CONV;
            end
          end else if (r_state != ST_IDLE) begin
            if (w_sck_rise && (r_cap_cnt < CAP_FULL)) begin
              r_cap     <= {r_cap[CMD_BITS-2:0], w_sdi_lvl};
              r_cap_cnt <= r_cap_cnt + 3'd1;
            end
            if (w_sck_fall) begin
              r_state <= ST_SHIFT;
              if (r_tail) begin
                r_sdo <= 1'b0;
              end else begin
                r_sdo <= r_result[r_idx];
                if (r_idx == 4'd0) begin
                  r_tail <= 1'b1;
                end else begin
                  r_idx <= r_idx - 4'd1;
                end
              end
            end
          end
        end

        ST_CONV: begin
          if (r_cnt == '0) begin
            r_busy    <= 1'b0;
            r_sdo     <= r_result[DATA_BITS-1];
            r_idx     <= 4'(DATA_BITS - 2);
            r_tail    <= 1'b0;
            r_cap_cnt <= '0;
            r_state   <= ST_READY;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_SLEEP: begin
          // Wake-up also clears SLP in the pending word so the following
          // CONVST converts instead of going straight back to sleep.
          if (w_convst_rise) begin
            r_active[CFG_SLP]  <= 1'b0;
            r_pending[CFG_SLP] <= 1'b0;
            r_state            <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign adc.ADC_SDO   = r_sdo;
  assign busy          = r_busy;
  assign active_cfg    = r_active;
  assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_ltc2308_emulator.sv
module tb_ltc2308_emulator;

  localparam int SYNC = 2;
  localparam int CONV = 64;
  localparam logic [5:0] DEF_CFG = 6'b100010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [95:0] ch_data;
  logic        busy;
  logic [5:0]  active_cfg;
  logic        sample_strobe;

  ltc2308_emulator_if adc_bus ();

  ltc2308_emulator #(.SYNC_STAGES(SYNC), .CONV_CYCLES(CONV)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ch_data       (ch_data),
    .adc           (adc_bus),
    .busy          (busy),
    .active_cfg    (active_cfg),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (ADC behaviour, not RTL structure) -----
  logic [5:0] m_pending, m_active, m_cap;
  int         m_nbits;
  bit         m_sleep;
  bit         m_exp_conv;
  int         m_result;

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic int chan_val(logic [95:0] d, int ch);
    logic [95:0] t;
    t = d >> (12 * ch);
    return int'(t[11:0]);
  endfunction

  function automatic int ref_result(logic [5:0] cfg, logic [95:0] d);
    int os, pair, vp, vn, diff;
    os   = cfg[4] ? 1 : 0;
    pair = (cfg[3] ? 2 : 0) + (cfg[2] ? 1 : 0);
    vp   = chan_val(d, 2 * pair + os);
    vn   = chan_val(d, 2 * pair + 1 - os);
    if (cfg[5]) return cfg[1] ? vp : (vp ^ 2048);
    diff = vp - vn;
    if (cfg[1]) return (diff < 0) ? 0 : ((diff > 4095) ? 4095 : diff);
    return (diff >>> 1) & 4095;
  endfunction

  task automatic model_reset();
    m_pending = DEF_CFG;
    m_active  = DEF_CFG;
    m_cap     = '0;
    m_nbits   = 0;
    m_sleep   = 0;
    m_result  = 0;
  endtask

  task automatic model_convst();
    if (m_sleep) begin
      m_active[0]  = 1'b0;
      m_pending[0] = 1'b0;
      m_sleep      = 0;
      m_exp_conv   = 0;
    end else begin
      if (m_nbits >= 6) m_pending = m_cap;
      m_active = m_pending;
      m_nbits  = 0;
      if (m_active[0]) begin
        m_sleep    = 1;
        m_exp_conv = 0;
      end else begin
        m_exp_conv = 1;
        m_result   = ref_result(m_active, ch_data);
      end
    end
  endtask

  task automatic model_read(input int nsck, input logic [5:0] w);
    for (int i = 0; i < nsck; i++) begin
      if (m_nbits < 6) begin
        m_cap   = {m_cap[4:0], (i < 6) ? w[5 - i] : 1'b0};
        m_nbits = m_nbits + 1;
      end
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic conv_step(input int repulse, input bit scramble, input string tag);
    int busy_len, fall_at, strobes;
    bit prev;
    model_convst();
    busy_len = 0; fall_at = -1; strobes = 0; prev = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
      if (busy) busy_len++;
      if (prev && !busy && fall_at < 0) fall_at = k;
      prev = busy;
      if (k == 0) adc_bus.ADC_CONVST = 1'b1;
      if (k == 4) adc_bus.ADC_CONVST = 1'b0;
      if (repulse > 0 && k == repulse)     adc_bus.ADC_CONVST = 1'b1;
      if (repulse > 0 && k == repulse + 4) adc_bus.ADC_CONVST = 1'b0;
      if (scramble && k == 30) ch_data = rand96();
    end
    chk({tag, "_strobe"}, strobes, m_exp_conv ? 1 : 0);
    chk({tag, "_busylen"}, busy_len, m_exp_conv ? CONV : 0);
    if (m_exp_conv) chk({tag, "_busyfall"}, fall_at, SYNC + 1 + CONV);
    else chk({tag, "_sdo0"}, adc_bus.ADC_SDO, 1'b0);
    chk({tag, "_cfg"}, active_cfg, m_active);
  endtask

  task automatic read_step(input int nsck, input logic [5:0] w, input string tag,
                           output logic [15:0] got);
    logic [15:0] exp;
    got = '0; exp = '0;
    for (int i = 0; i < nsck; i++) begin
      adc_bus.ADC_SDI = (i < 6) ? w[5 - i] : 1'b0;
      repeat (4) @(negedge clk);
      got = {got[14:0], adc_bus.ADC_SDO};
      exp = {exp[14:0], (i < 12) ? 1'((m_result >> (11 - i)) & 1) : 1'b0};
      adc_bus.ADC_SCK = 1'b1;
      repeat (4) @(negedge clk);
      adc_bus.ADC_SCK = 1'b0;
    end
    adc_bus.ADC_SDI = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_data"}, got, exp);
    model_read(nsck, w);
  endtask

  logic [15:0] got;

  initial begin
    reset_n = 1'b0;
    adc_bus.ADC_CONVST = 1'b0;
    adc_bus.ADC_SCK    = 1'b0;
    adc_bus.ADC_SDI    = 1'b0;
    ch_data = rand96();
    ch_data[11:0]  = 12'hABC;
    ch_data[23:12] = 12'h123;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sdo",    adc_bus.ADC_SDO, 1'b0);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_strobe", sample_strobe, 1'b0);
    chk("rst_cfg",    active_cfg, DEF_CFG);

    // ch0 read with default config, config word for ch1 shifted meanwhile
    conv_step(0, 0, "A");
    read_step(14, 6'b110010, "A", got);
    chk("A_lit", got, 16'h2AF0);
    conv_step(0, 0, "B");
    chk("B_cfg_lit", active_cfg, 6'b110010);
    read_step(12, 6'b100010, "B", got);
    chk("B_lit", got, 16'h0123);
    // partial config word is discarded
    conv_step(0, 0, "C");
    read_step(3, 6'b110000, "C", got);
    conv_step(0, 0, "D");
    chk("D_cfg_lit", active_cfg, DEF_CFG);
    read_step(12, 6'b000000, "D", got);
    chk("D_lit", got, 16'h0ABC);
    // differential, bipolar and unipolar-clamped
    ch_data[11:0]  = 12'd100;
    ch_data[23:12] = 12'd300;
    conv_step(0, 0, "E");
    read_step(12, 6'b000010, "E", got);
    chk("E_lit", got, 16'h0F9C);
    conv_step(0, 0, "F");
    read_step(12, 6'b110010, "F", got);
    chk("F_lit", got, 16'h0000);
    // CONVST re-pulsed during CONV is ignored
    conv_step(20, 0, "G");
    read_step(5, 6'b100010, "G", got);
    // CONVST during SHIFT aborts it
    conv_step(0, 0, "H");
    read_step(12, 6'b100011, "H", got);
    // sleep, wake, then a normal conversion
    conv_step(0, 0, "I");
    chk("I_cfg_lit", active_cfg, 6'b100011);
    conv_step(0, 0, "J");
    conv_step(0, 0, "K");
    read_step(12, 6'b100010, "K", got);
    chk("K_lit", got, 16'h0064);

    // randomized configs and data; ch_data scrambled mid-conversion
    for (int it = 0; it < 20; it++) begin
      ch_data = rand96();
      conv_step(0, 1, "rnd");
      read_step(int'($urandom_range(3, 14)), 6'($urandom) & 6'b111110, "rnd", got);
    end

    // reset in the middle of a read
    conv_step(0, 0, "R");
    read_step(4, 6'b011011, "R", got);
    adc_bus.ADC_SCK = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("R_rst_sdo",  adc_bus.ADC_SDO, 1'b0);
    chk("R_rst_busy", busy, 1'b0);
    chk("R_rst_cfg",  active_cfg, DEF_CFG);
    adc_bus.ADC_SCK = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    conv_step(0, 0, "R2");
    read_step(12, 6'b100010, "R2", got);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ltc2308_emulator.md
Name: ltc2308_emulator

Overview:
- Synthesizable responder model of the LTC2308 8-channel 12-bit SAR ADC serial interface.
- Drives ADC_SDO in response to ADC_CONVST/ADC_SCK/ADC_SDI from the existing ADC controller, for hardware-in-the-loop and self-test of the power-monitor datapath without the physical ADC.
- Channel values come from a parallel `ch_data` bus, loaded by a pattern generator or a host register bank.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each ADC input (min 2).
- CONV_CYCLES, 64, clk cycles the emulated conversion stays busy after a CONVST rising edge (min 1).

Ports:
- clk  in  1  emulator clock; must be ≥4× ADC_SCK frequency.
- reset_n  in  1  asynchronous active-low reset.
- ch_data  in  96  eight 12-bit channel values; ch N = ch_data[12N+11:12N].
- ADC_CONVST  in  1  conversion start; asynchronous to clk.
- ADC_SCK  in  1  serial clock; asynchronous to clk.
- ADC_SDI  in  1  config bit stream, MSB first.
- ADC_SDO  out  1  result bit stream, MSB first.
- busy  out  1  high during CONV state.
- active_cfg  out  6  config word governing the current or last conversion: {S/D, O/S, S1, S0, UNI, SLP}.
- sample_strobe  out  1  one-cycle pulse when a result is latched.

Behaviour:
- Reset values: ADC_SDO=0, busy=0, sample_strobe=0, active_cfg=6'b100010 (single-ended ch0, unipolar, no sleep), pending config = same, state IDLE.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. Edge-to-action latency is SYNC_STAGES+1 clk.
- SCK high and low phases must each be ≥2 clk. Faster SCK is out of spec and behaviour is undefined.
- States: IDLE, CONV, READY, SHIFT, SLEEP.
- CONVST rise in IDLE, READY or SHIFT:
  - If ≥6 SDI bits were captured since the last conversion end, pending config := captured bits; otherwise pending is unchanged.
  - active_cfg := pending.
  - If SLP=0: latch result, pulse sample_strobe, busy=1, load counter CONV_CYCLES-1, go to CONV.
  - If SLP=1: go to SLEEP, ADC_SDO=0.
  - An in-progress SHIFT is aborted.
- CONVST rise in CONV: ignored. The counter is not restarted.
- SLEEP: the next CONVST rise clears active_cfg SLP and returns to IDLE. No conversion starts and sample_strobe does not pulse.
- CONV: the counter decrements each clk. At 0: busy=0, ADC_SDO=result[11], bit index=10, SDI capture count=0, go to READY.
- READY/SHIFT, SCK rising edge: if capture count <6, shift ADC_SDI into the 6-bit capture register and increment the count (saturates at 6). Further rising edges are ignored for config.
- READY/SHIFT, SCK falling edge:
  - If index ≥0: ADC_SDO=result[index], index decrements, state SHIFT.
  - After the falling edge that outputs bit 0, the next falling edge sets ADC_SDO=0; extra SCK edges hold ADC_SDO at 0.
- Channel select: ch = {S1, S0, O/S}, so SDI nibble 8/C/9/D/A/E/B/F maps to ch0..7.
- Result computation, latched at CONVST rise from the ch_data sample of that cycle:
  - Single-ended, UNI=1: result = ch_data[ch].
  - Single-ended, UNI=0: result = ch_data[ch] ^ 12'h800 (two's complement).
  - Differential (S/D=0): pair p = {S1, S0}. O/S=0 selects + = ch 2p, − = ch 2p+1; O/S=1 swaps them.
  - Differential difference d is 13-bit signed (+ minus −).
  - Differential UNI=1: result = clamp(d, 0, 4095).
  - Differential UNI=0: result = d>>>1 truncated to 12 bits.
- ch_data changes after the latch do not affect an in-flight result.
- reset_n low mid-operation returns everything to reset values immediately; the synchronizer and edge flops are cleared.

Optional Feature:
- Macro LTC2308_EMU_NOISE_EN.
- Defined: a 16-bit Galois LFSR (poly 0xB400, seed 0xACE1 on reset) advances once per conversion. Its bits [1:0] are XORed into result[1:0] after clamping.
- Undefined: no LFSR is present and results are exact.

Decomposition:
- Shared package ltc2308_pkg holds:
  - the state enum;
  - CFG bit-index constants (CFG_SD=5, CFG_OS=4, CFG_S1=3, CFG_S0=2, CFG_UNI=1, CFG_SLP=0);
  - RESET_CFG=6'b100010;
  - DATA_BITS=12, CMD_BITS=6.
- One sub-module: ltc2308_emu_sync, a parameterized synchronizer plus rise/fall edge detector, instantiated three times.

Test Plan:
- Reset, ch_data ch0=12'hABC, CONVST pulse, 12 SCK → SDO stream 1010_1011_1100, busy high for 64 clk, sample_strobe pulses once.
- During read 1 shift SDI 6'b110010; read 2 returns ch1 value 12'h123 and active_cfg=6'b110010.
- Only 3 SDI bits shifted before the next CONVST → active_cfg unchanged, ch0 returned.
- Differential, cfg 6'b000000, ch0=100, ch1=300 → result 12'hF9C (−100). With cfg 6'b000010 → 12'h000 (clamped).
- CONVST re-pulsed mid-CONV → ignored, busy ends 64 clk after the first edge. CONVST during SHIFT after 5 bits → SHIFT aborted, new conversion runs.
- Config with SLP=1 → SLEEP, no strobe, SDO=0. Next CONVST → IDLE; following CONVST converts normally.
